// File: rtl/fuzz_ctrl_pkg.sv
// Shared types and constants for the fuzzing round sequencer: state encoding,
// verdict codes, default parameters and the saturating counter increment.
package fuzz_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RST    = 3'd2,
    ST_RUN    = 3'd3,
    ST_REPORT = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    REASON_NONE    = 2'd0,
    REASON_PASS    = 2'd1,
    REASON_FAIL    = 2'd2,
    REASON_TIMEOUT = 2'd3
  } reason_e;

  localparam int unsigned DEF_RESET_CYCLES = 32'd8;
  localparam int unsigned DEF_COV_W        = 32'd32;
  localparam int unsigned CNT_W            = 32'd64;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fuzz_watchdog.sv
// Per-round RUN cycle counter (64-bit, saturating) and run-length limit compare.
// timeout_o flags the cycle in which the completed-cycle count reaches the limit.
module fuzz_watchdog
  import fuzz_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] max_i,
  output logic [CNT_W-1:0] cnt_inc_o,
  output logic             timeout_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] max_q;

  // Counter clears and limit latches together when a new round leaves LOAD.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 64'd0;
      max_q <= 64'd0;
    end else if (clr_i) begin
      cnt_q <= 64'd0;
      max_q <= max_i;
    end else if (en_i) begin
      cnt_q <= sat_inc(cnt_q);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_inc_o = sat_inc(cnt_q);
  assign timeout_o = (max_q != 64'd0) && (cnt_q == max_q);

endmodule

// File: rtl/fuzz_round_ctrl.sv
// Round sequencer for the RTL fuzzing loop: drives DUT meta-reset and clock
// enable, handshakes testcase reloads with the host and records per-round verdicts.
module fuzz_round_ctrl
  import fuzz_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned COV_W        = DEF_COV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [63:0]      max_cycles,
  input  logic             load_ack,
  input  logic             finish,
  input  logic             fail,
  input  logic [COV_W-1:0] cov_sum,
  output logic             dut_reset,
  output logic             dut_clk_en,
  output logic             load_req,
  output logic             busy,
  output logic             round_done,
  output logic [1:0]       round_reason,
  output logic [63:0]      round_cycles,
  output logic [COV_W-1:0] round_cov,
  output logic [31:0]      round_count
);

  state_e           state_q, state_d;
  logic [31:0]      rst_cnt_q, rst_cnt_d;
  reason_e          reason_q, reason_d;
  logic [63:0]      cycles_q, cycles_d;
  logic [COV_W-1:0] cov_q, cov_d;
  logic [31:0]      count_q, count_d;

  reason_e          verdict_s;
  logic             wd_clr_s;
  logic             wd_en_s;
  logic             timeout_s;
  logic [63:0]      cnt_inc_s;

  fuzz_watchdog u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (wd_clr_s),
    .en_i      (wd_en_s),
    .max_i     (max_cycles),
    .cnt_inc_o (cnt_inc_s),
    .timeout_o (timeout_s)
  );

  // Next-state, verdict resolution and result-register updates.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    reason_d  = reason_q;
    cycles_d  = cycles_q;
    cov_d     = cov_q;
    count_d   = count_q;
    verdict_s = REASON_NONE;
    wd_clr_s  = 1'b0;
    wd_en_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_ack) begin
          state_d   = ST_RST;
          rst_cnt_d = 32'd0;
          wd_clr_s  = 1'b1;
        end else begin
          state_d   = ST_LOAD;
        end
      end
      ST_RST: begin
        if (rst_cnt_q == RESET_CYCLES - 32'd1) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      ST_RUN: begin
        // fail outranks timeout, which outranks finish
        if (fail) begin
          verdict_s = REASON_FAIL;
        end else if (timeout_s) begin
          verdict_s = REASON_TIMEOUT;
        end else if (finish) begin
          verdict_s = REASON_PASS;
        end else begin
          wd_en_s   = 1'b1;
        end
        if (verdict_s != REASON_NONE) begin
          state_d  = ST_REPORT;
          reason_d = verdict_s;
          cycles_d = cnt_inc_s;
          cov_d    = cov_sum;
          count_d  = count_q + 32'd1;
        end else begin
          state_d  = ST_RUN;
        end
      end
      ST_REPORT: begin
        if ((reason_q == REASON_PASS) && continuous) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= 32'd0;
      reason_q  <= REASON_NONE;
      cycles_q  <= 64'd0;
      cov_q     <= '0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      reason_q  <= reason_d;
      cycles_q  <= cycles_d;
      cov_q     <= cov_d;
      count_q   <= count_d;
    end
  end

  assign dut_reset    = (state_q != ST_RUN);
  assign dut_clk_en   = (state_q == ST_RST) || (state_q == ST_RUN);
  assign load_req     = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign round_done   = (state_q == ST_REPORT);
  assign round_reason = reason_q;
  assign round_cycles = cycles_q;
  assign round_cov    = cov_q;
  assign round_count  = count_q;

endmodule

// File: doc/fuzz_round_ctrl.md
# fuzz_round_ctrl

Synthesizable sequencer for the RTL-fuzzing loop around the SoC test harness. It owns the DUT's meta-reset and clock enable, and requests testcase reloads (memory image plus cosim reinit) through a host handshake. It runs a cycle watchdog and reports a pass, fail or timeout verdict for each round. In continuous (fuzzing) mode it chains rounds back-to-back, which replaces the behavioural reset/force/reload task in the bench.

## Interface
Parameters:
- RESET_CYCLES, 8: cycles the DUT reset is held with its clock enabled before each run (≥1).
- COV_W, 32: width of the coverage-sum input.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a campaign; sampled only in IDLE or HALT.
- continuous  in  1  1 = after a pass, start the next round automatically.
- max_cycles  in  64  run-length limit; 0 disables the watchdog; sampled when LOAD exits.
- load_ack  in  1  host finished loading the testcase; pulse or level.
- finish  in  1  DUT completion indication.
- fail  in  1  cosim mismatch or DUT-reported failure.
- cov_sum  in  COV_W  DUT coverage sum.
- dut_reset  out  1  DUT meta-reset.
- dut_clk_en  out  1  DUT clock enable, for the integration clock gate.
- load_req  out  1  request a testcase reload.
- busy  out  1  high in every state except IDLE and HALT.
- round_done  out  1  one-cycle pulse when a verdict is produced.
- round_reason  out  2  verdict code: 0 none, 1 pass, 2 fail, 3 timeout.
- round_cycles  out  64  number of RUN cycles in the last round.
- round_cov  out  COV_W  cov_sum captured at the verdict.
- round_count  out  32  completed rounds; wraps at 2^32.

## Operation
States: IDLE, LOAD, RST, RUN, REPORT, HALT.

- **IDLE**
  - Outputs: dut_reset=1, dut_clk_en=0.
  - start → LOAD.
- **LOAD**
  - Outputs: dut_reset=1, dut_clk_en=0, load_req=1.
  - load_ack → RST.
  - On that transition: latch max_cycles, clear run_cnt.
  - load_ack seen outside LOAD is ignored.
- **RST**
  - Outputs: dut_reset=1, dut_clk_en=1.
  - Stays exactly RESET_CYCLES cycles, then → RUN.
- **RUN**
  - Outputs: dut_reset=0, dut_clk_en=1.
  - run_cnt is the number of RUN cycles completed before the current cycle.
  - Each RUN cycle resolves in this priority order:
    1. fail → reason 2.
    2. Latched max≠0 and run_cnt==max → reason 3.
    3. finish → reason 1.
    4. Otherwise run_cnt+=1 and stay in RUN.
  - On any verdict: round_cycles←run_cnt+1, round_cov←cov_sum, round_reason←reason; → REPORT.
- **REPORT** (one cycle)
  - Outputs: round_done=1, round_count+=1, dut_reset=1, dut_clk_en=0.
  - Exit: reason 1 with continuous=1 → LOAD; anything else → HALT.
- **HALT**
  - Outputs: dut_reset=1, dut_clk_en=0.
  - Result registers hold their values.
  - start → LOAD; round_count is not cleared.

Width rules:
- run_cnt is 64 bits and saturates at 2^64−1.
- round_cycles takes the saturated value.
- round_count wraps.

Reset (any state, including mid-RUN): next state is IDLE. Output values after reset:
- dut_reset=1.
- dut_clk_en, load_req, round_done, busy = 0.
- round_reason=0, round_cycles=0, round_cov=0, round_count=0.

## Timing
- All outputs are registered, apart from being decoded directly from the state register.
- No output depends combinationally on any input.
- start → load_req high: next cycle.
- load_ack in cycle N: load_req low and dut_reset still 1 in N+1. RST occupies N+1…N+RESET_CYCLES. First cycle with dut_reset=0 is N+RESET_CYCLES+1.
- Verdict in RUN cycle M: round_done and the new result registers are visible in M+1. For continuous pass rounds, load_req rises in M+2.
- finish and fail are ignored outside RUN.
- finish and fail asserted in the same cycle: fail wins.
- finish in the timeout cycle: timeout wins.
- dut_reset drops to 0 only in RUN, so the DUT is guaranteed at least RESET_CYCLES clocked reset cycles per round.

## Structure
- Package fuzz_ctrl_pkg holds:
  - the state enum (3-bit encoding);
  - the reason codes REASON_NONE, REASON_PASS, REASON_FAIL, REASON_TIMEOUT;
  - the default constants for RESET_CYCLES and COV_W.
- One sub-module is natural: fuzz_watchdog.
  - It contains the 64-bit saturating run counter with its clear/enable controls and the max compare.
  - Its output is a timeout flag for the current cycle.
- The FSM, handshake and result registers remain in fuzz_round_ctrl.

## Test plan
- **Single pass.** Stimulus: RESET_CYCLES=8, continuous=0, max=0; start; load_ack 3 cycles later; finish on the 100th RUN cycle. Required: exactly 8 dut_reset=1 cycles with dut_clk_en=1; round_reason=1, round_cycles=100, round_count=1; state HALT, busy=0.
- **Timeout.** Stimulus: max=10, finish never asserted. Required: verdict on the 11th RUN cycle; reason 3, round_cycles=11.
- **Same-cycle priorities.** Stimulus: max=10, with finish and fail together on RUN cycle 11. Required: reason 2. Second run with finish alone on cycle 11: reason 3. Third run with finish alone on cycle 10: reason 1.
- **Continuous mode.** Stimulus: continuous=1; three rounds each ending in finish. Required: load_req re-asserts 2 cycles after each verdict; round_count=3. A fail in round 4 leaves the block in HALT with round_count=4.
- **Reset mid-RUN.** Stimulus: synchronous reset at RUN cycle 50. Required: next cycle in IDLE with all outputs at reset values. A later start followed by load_ack runs a clean round with round_cycles counted from 1.
- **Handshake robustness.** Stimulus: load_ack held high for 5 cycles; stray load_ack and finish in HALT. Required: only one LOAD→RST transition; no state change while in HALT.
